// File: rtl/sha_para_to_serial_stream.sv
// Parallel-to-serial unpacker: loads a NUM_WORDS*WORD_W block and streams it as WORD_W words.
// Optional synchronous flush input enabled by defining SHA_PTS_FLUSH_EN.
module sha_para_to_serial_stream #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8,
  parameter int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef SHA_PTS_FLUSH_EN
  input  logic                        flush,
`endif
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [WORD_W*NUM_WORDS-1:0] load_data,
  input  logic                        word_order,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W-1:0]           out_data,
  output logic                        out_last,
  output logic [IDX_W-1:0]            out_index,
  output logic                        busy
);

  localparam int BLK_W = WORD_W * NUM_WORDS;
  localparam logic [IDX_W-1:0] PRE_LAST_IDX = IDX_W'(NUM_WORDS - 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_reg, state_next;
  logic [BLK_W-1:0]   shift_reg, shift_next;
  logic [BLK_W-1:0]   reversed_data, ordered_data;
  logic               valid_reg, valid_next;
  logic               last_reg, last_next;
  logic [IDX_W-1:0]   index_reg, index_next;
  logic               flush_w, out_fire, load_fire;

`ifdef SHA_PTS_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Word order is resolved at capture time: reversing the block once lets the
  // shifter always emit from the MSB end.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_rev
      assign reversed_data[BLK_W-1-gi*WORD_W -: WORD_W] =
        load_data[BLK_W-1-(NUM_WORDS-1-gi)*WORD_W -: WORD_W];
    end
  endgenerate

  assign ordered_data = word_order ? reversed_data : load_data;
  assign out_fire     = valid_reg & out_ready;
  assign load_ready   = !flush_w & ((state_reg == IDLE) | (out_fire & last_reg));
  assign load_fire    = load_valid & load_ready;

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    index_next = index_reg;
    if (flush_w) begin
      state_next = IDLE;
      valid_next = 1'b0;
      last_next  = 1'b0;
      index_next = '0;
    end else if (load_fire) begin
      // Also covers the back-to-back handoff on the final word of a block.
      state_next = SHIFT;
      shift_next = ordered_data;
      valid_next = 1'b1;
      last_next  = 1'b0;
      index_next = '0;
    end else if (state_reg == SHIFT && out_fire) begin
      if (last_reg) begin
        state_next = IDLE;
        valid_next = 1'b0;
        last_next  = 1'b0;
        index_next = '0;
      end else begin
        shift_next = shift_reg << WORD_W;
        index_next = index_reg + 1'b1;
        last_next  = (index_reg == PRE_LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      index_reg <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      index_reg <= index_next;
    end
  end

  // The head word stays put after the block ends, so out_data holds its last value.
  assign out_data  = shift_reg[BLK_W-1 -: WORD_W];
  assign out_valid = valid_reg;
  assign out_last  = last_reg;
  assign out_index = index_reg;
  assign busy      = (state_reg == SHIFT);

endmodule

// File: tb/tb_sha_para_to_serial_stream.sv
// Self-checking bench for sha_para_to_serial_stream with a queue-based reference model.
// Define SHA_PTS_FLUSH_EN to also exercise the flush input.
module tb_sha_para_to_serial_stream;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int BW = W * N;

  logic          clk = 1'b0;
  logic          rst_n;
`ifdef SHA_PTS_FLUSH_EN
  logic          flush;
`endif
  logic          load_valid;
  logic          load_ready;
  logic [BW-1:0] load_data;
  logic          word_order;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic [2:0]    out_index;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] got_data[$];
  int           got_idx[$];
  logic         got_last[$];
  int           stall_err;

  localparam logic [BW-1:0] SHA_H = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [BW-1:0] DEAD  = {8{32'hdeadbeef}};

  always #5 clk = ~clk;

  sha_para_to_serial_stream #(.WORD_W(W), .NUM_WORDS(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SHA_PTS_FLUSH_EN
    .flush      (flush),
`endif
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .word_order (word_order),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_index  (out_index),
    .busy       (busy)
  );

  // Reference: the k-th emitted word of a block, using plain shifts of the whole block.
  function automatic logic [W-1:0] model_word(input logic [BW-1:0] blk, input logic ord, input int k);
    int            j;
    logic [BW-1:0] sh;
    j  = ord ? (N - 1 - k) : k;
    sh = blk >> (W * (N - 1 - j));
    return sh[W-1:0];
  endfunction

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) b = (b << W) | BW'($urandom);
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_block(input logic [BW-1:0] blk, input logic ord);
    int cyc;
    cyc        = 0;
    load_data  = blk;
    word_order = ord;
    load_valid = 1'b1;
    while (!load_ready && cyc < 200) begin
      step();
      cyc++;
    end
    step();
    load_valid = 1'b0;
  endtask

  // Collects n output handshakes; pct<0 selects the fixed 1,0,0 ready pattern.
  task automatic drain(input int n, input int pct);
    logic [W-1:0] hd;
    logic [2:0]   hi;
    logic         hl;
    logic         hold;
    got_data.delete();
    got_idx.delete();
    got_last.delete();
    stall_err = 0;
    hold      = 1'b0;
    hd = '0; hi = '0; hl = 1'b0;
    for (int cyc = 0; cyc < 2000 && got_data.size() < n; cyc++) begin
      out_ready  = (pct < 0) ? (cyc % 3 == 0) : ($urandom_range(99) < pct);
      word_order = 1'($urandom);
      if (hold && (out_valid !== 1'b1 || out_data !== hd || out_index !== hi || out_last !== hl))
        stall_err++;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_idx.push_back(int'(out_index));
        got_last.push_back(out_last);
      end
      hold = out_valid && !out_ready;
      hd = out_data; hi = out_index; hl = out_last;
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; word_order = 1'b0; out_ready = 1'b0;
`ifdef SHA_PTS_FLUSH_EN
    flush = 1'b0;
`endif
    step(); step();
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_index !== 3'd0 || out_last !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b d=%h i=%0d l=%b busy=%b want all zero",
               out_valid, out_data, out_index, out_last, busy);
    end
    rst_n = 1'b1;
    step();
    total++;
    if (load_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_load_ready got %b want 1", load_ready);
    end
  endtask

  task automatic test_order(input logic ord, input int pct, input string name);
    load_block(SHA_H, ord);
    drain(N, pct);
    for (int i = 0; i < N; i++) begin
      total++;
      if (got_data.size() <= i || got_data[i] !== model_word(SHA_H, ord, i) ||
          got_idx[i] != i || got_last[i] !== (i == N - 1)) begin
        bad++;
        $display("FAIL %s word%0d got cnt=%0d d=%h i=%0d l=%b want d=%h i=%0d l=%b", name, i,
                 got_data.size(), (got_data.size() > i) ? got_data[i] : '0,
                 (got_idx.size() > i) ? got_idx[i] : -1, (got_last.size() > i) ? got_last[i] : 1'b0,
                 model_word(SHA_H, ord, i), i, (i == N - 1));
      end
    end
    total++;
    if (stall_err != 0 || out_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s end got stall_err=%0d v=%b busy=%b lr=%b want 0 0 0 1",
               name, stall_err, out_valid, busy, load_ready);
    end
    $display("%s: %0d words received", name, got_data.size());
  endtask

  task automatic test_back_to_back();
    load_block(SHA_H, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < N - 1; i++) step();
    load_data  = DEAD;
    word_order = 1'b0;
    load_valid = 1'b1;
    total++;
    if (out_last !== 1'b1 || out_index !== 3'd7 || out_data !== 32'h5be0cd19 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_handoff got l=%b i=%0d d=%h lr=%b want 1 7 5be0cd19 1",
               out_last, out_index, out_data, load_ready);
    end
    step();
    load_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hdeadbeef || out_index !== 3'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first got v=%b d=%h i=%0d busy=%b want 1 deadbeef 0 1",
               out_valid, out_data, out_index, busy);
    end
    drain(N, 100);
    for (int i = 0; i < N; i++) begin
      total++;
      if (got_data.size() <= i || got_data[i] !== model_word(DEAD, 1'b0, i) ||
          got_idx[i] != i || got_last[i] !== (i == N - 1)) begin
        bad++;
        $display("FAIL b2b word%0d got cnt=%0d want d=%h i=%0d", i, got_data.size(),
                 model_word(DEAD, 1'b0, i), i);
      end
    end
    $display("back_to_back: second block %0d words", got_data.size());
  endtask

  task automatic test_reset_mid();
    int seen;
    load_block(SHA_H, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_index !== 3'd0 || out_last !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_async got v=%b d=%h i=%0d l=%b busy=%b want all zero",
               out_valid, out_data, out_index, out_last, busy);
    end
    #1;
    rst_n = 1'b1;
    #1;
    total++;
    if (load_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_load_ready got %b want 1", load_ready);
    end
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_mid_no_words got %0d valid cycles want 0", seen);
    end
    $display("reset_mid: %0d stale words after reset", seen);
  endtask

  task automatic test_random();
    logic [BW-1:0] blk;
    logic          ord;
    for (int b = 0; b < 6; b++) begin
      blk = rand_block();
      ord = 1'($urandom);
      load_block(blk, ord);
      drain(N, 50);
      for (int i = 0; i < N; i++) begin
        total++;
        if (got_data.size() <= i || got_data[i] !== model_word(blk, ord, i) ||
            got_idx[i] != i || got_last[i] !== (i == N - 1)) begin
          bad++;
          $display("FAIL random b%0d word%0d got cnt=%0d want d=%h i=%0d", b, i,
                   got_data.size(), model_word(blk, ord, i), i);
        end
      end
      total++;
      if (stall_err != 0) begin
        bad++;
        $display("FAIL random b%0d stall got %0d changes want 0", b, stall_err);
      end
      $display("random block %0d order=%0b: %0d words", b, ord, got_data.size());
    end
  endtask

`ifdef SHA_PTS_FLUSH_EN
  task automatic test_flush();
    logic [BW-1:0] blk;
    load_block(SHA_H, 1'b0);
    out_ready = 1'b1;
    step(); step();
    flush      = 1'b1;
    load_data  = DEAD;
    load_valid = 1'b1;
    total++;
    if (load_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_load_ready got %b want 0", load_ready);
    end
    step();
    flush      = 1'b0;
    load_valid = 1'b0;
    out_ready  = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_index !== 3'd0 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle got v=%b busy=%b i=%0d l=%b want 0 0 0 0",
               out_valid, busy, out_index, out_last);
    end
    blk = rand_block();
    load_block(blk, 1'b0);
    drain(N, 100);
    for (int i = 0; i < N; i++) begin
      total++;
      if (got_data.size() <= i || got_data[i] !== model_word(blk, 1'b0, i) || got_idx[i] != i) begin
        bad++;
        $display("FAIL flush_reload word%0d got cnt=%0d want d=%h i=%0d", i, got_data.size(),
                 model_word(blk, 1'b0, i), i);
      end
    end
    $display("flush: reload streamed %0d words", got_data.size());
  endtask
`endif

  initial begin
    test_reset();
    test_order(1'b0, 100, "order0");
    test_order(1'b1, 100, "order1");
    test_order(1'b0, -1, "backpressure");
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef SHA_PTS_FLUSH_EN
    test_flush();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
